// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    localparam int unsigned ROM_WIDTH_DEF  = 21;
    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned RESET_PC_DEF   = 0;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the async program ROM from the pc and holds the
// returned word in a one-entry IR presented to the decoder via valid/ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_WIDTH  = ROM_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic [ROM_WIDTH-1:0]  ir_data,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  halted
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ROM_WIDTH-1:0]  ir_data_q, ir_data_d;
    logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
    logic                  ir_valid_q, ir_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= ADDR_WIDTH'(RESET_PC);
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Jump wins over everything; it flushes the IR even if the decoder takes it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        case (state_q)
            FETCH: begin
                if (jump_en) begin
                    pc_d       = jump_addr;
                    ir_valid_d = 1'b0;
                    if (halt_req) begin
                        state_d = HALT;
                    end
                end else if (halt_req) begin
                    state_d = HALT;
                    if (ir_valid_q && ir_ready) begin
                        ir_valid_d = 1'b0;
                    end
                end else if (!ir_valid_q || ir_ready) begin
                    ir_data_d  = rom_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_WIDTH'(1);
                end
            end
            HALT: begin
                if (jump_en) begin
                    pc_d       = jump_addr;
                    ir_valid_d = 1'b0;
                end else begin
                    if (ir_valid_q && ir_ready) begin
                        ir_valid_d = 1'b0;
                    end
                    if (resume && !halt_req) begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign rom_addr = pc_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [20:0] rom_data;
    logic [20:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        halt_req;
    logic        resume;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [20:0] prog [10];

    // Behavioural model state
    logic [15:0] m_pc;
    logic [20:0] m_ird;
    logic [15:0] m_irpc;
    logic        m_valid;
    logic        m_halt;

    instr_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .halt_req  (halt_req),
        .resume    (resume),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] rom_fn(input logic [15:0] a);
        if (int'(a) < 10) return prog[int'(a)];
        return {5'h15, a};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_ird   = '0;
        m_irpc  = '0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs applied before the edge.
    task automatic step();
        logic [15:0] npc;
        logic [20:0] nd;
        logic [15:0] nipc;
        logic        nv;
        logic        nh;
        npc = m_pc; nd = m_ird; nipc = m_irpc; nv = m_valid; nh = m_halt;
        if (jump_en) begin
            npc = jump_addr;
            nv  = 1'b0;
            if (!m_halt && halt_req) nh = 1'b1;
        end else if (!m_halt) begin
            if (halt_req) begin
                nh = 1'b1;
                if (m_valid && ir_ready) nv = 1'b0;
            end else if (!m_valid || ir_ready) begin
                nd   = rom_fn(m_pc);
                nipc = m_pc;
                nv   = 1'b1;
                npc  = 16'((int'(m_pc) + 1) % 65536);
            end
        end else begin
            if (m_valid && ir_ready) nv = 1'b0;
            if (resume && !halt_req) nh = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_ird = nd; m_irpc = nipc; m_valid = nv; m_halt = nh;
    endtask

    task automatic clear_inputs();
        ir_ready  = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ir_valid, halted, rom_addr, ir_pc, ir_data} !== {1'b0, 1'b0, 16'h0, 16'h0, 21'h0}) begin
            failures++;
            $display("FAIL reset_values actual=v%b h%b a%h p%h d%h required=all zero",
                     ir_valid, halted, rom_addr, ir_pc, ir_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ir_valid, rom_addr} !== {1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_held_over_edge actual=v%b a%h required=v0 a0000", ir_valid, rom_addr);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'(i), prog[i]}) begin
                failures++;
                $display("FAIL seq_fetch_%0d actual=v%b p%h d%b required=v1 p%h d%b",
                         i, ir_valid, ir_pc, ir_data, 16'(i), prog[i]);
            end
        end
        checks++;
        if (ir_data !== 21'b010010000000000001001) begin
            failures++;
            $display("FAIL seq_last_word actual=%b required=010010000000000001001", ir_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ir_ready = 1'b1;
        repeat (3) step();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data, rom_addr} !== {1'b1, 16'h2, prog[2], 16'h3}) begin
                failures++;
                $display("FAIL stall_hold_%0d actual=v%b p%h d%h a%h required=v1 p0002 d%h a0003",
                         i, ir_valid, ir_pc, ir_data, rom_addr, prog[2]);
            end
        end
        ir_ready = 1'b1;
        for (int i = 3; i < 5; i++) begin
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'(i), prog[i]}) begin
                failures++;
                $display("FAIL stall_release_%0d actual=v%b p%h required=v1 p%h", i, ir_valid, ir_pc, 16'(i));
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        ir_ready = 1'b1;
        repeat (5) step();
        jump_en = 1'b1; jump_addr = 16'h9;
        step();
        jump_en = 1'b0;
        checks++;
        if ({ir_valid, rom_addr} !== {1'b0, 16'h9}) begin
            failures++;
            $display("FAIL jump_bubble actual=v%b a%h required=v0 a0009", ir_valid, rom_addr);
        end
        step();
        checks++;
        if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h9, prog[9]}) begin
            failures++;
            $display("FAIL jump_target actual=v%b p%h required=v1 p0009", ir_valid, ir_pc);
        end
        jump_en = 1'b1;
        repeat (3) step();
        checks++;
        if ({ir_valid, ir_pc, rom_addr} !== {1'b0, 16'h9, 16'h9}) begin
            failures++;
            $display("FAIL jump_repeat_hold actual=v%b p%h a%h required=v0 p0009 a0009", ir_valid, ir_pc, rom_addr);
        end
        jump_en = 1'b0;
        step();
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 16'h9}) begin
            failures++;
            $display("FAIL jump_repeat_target actual=v%b p%h required=v1 p0009", ir_valid, ir_pc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
        do_reset();
        ir_ready = 1'b1;
        jump_en = 1'b1; jump_addr = 16'hFFFE;
        step();
        jump_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, exp_pc[i], rom_fn(exp_pc[i])}) begin
                failures++;
                $display("FAIL wrap_%0d actual=v%b p%h required=v1 p%h", i, ir_valid, ir_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        ir_ready = 1'b1;
        repeat (6) step();
        ir_ready = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++;
        if ({halted, ir_valid, ir_pc, rom_addr} !== {1'b1, 1'b1, 16'h5, 16'h6}) begin
            failures++;
            $display("FAIL halt_enter actual=h%b v%b p%h a%h required=h1 v1 p0005 a0006",
                     halted, ir_valid, ir_pc, rom_addr);
        end
        ir_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({halted, ir_valid, rom_addr} !== {1'b1, 1'b0, 16'h6}) begin
            failures++;
            $display("FAIL halt_drain actual=h%b v%b a%h required=h1 v0 a0006", halted, ir_valid, rom_addr);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++;
        if ({halted, ir_valid} !== {1'b0, 1'b0}) begin
            failures++;
            $display("FAIL resume_first_edge actual=h%b v%b required=h0 v0", halted, ir_valid);
        end
        step();
        checks++;
        if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'h6, prog[6]}) begin
            failures++;
            $display("FAIL resume_load actual=v%b p%h required=v1 p0006", ir_valid, ir_pc);
        end
        jump_en = 1'b1; halt_req = 1'b1; jump_addr = 16'h1234;
        step();
        jump_en = 1'b0; halt_req = 1'b0;
        checks++;
        if ({halted, ir_valid, rom_addr} !== {1'b1, 1'b0, 16'h1234}) begin
            failures++;
            $display("FAIL jump_halt actual=h%b v%b a%h required=h1 v0 a1234", halted, ir_valid, rom_addr);
        end
        resume = 1'b1; halt_req = 1'b1;
        step();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL resume_vs_halt actual=h%b required=h1", halted);
        end
        halt_req = 1'b0;
        step();
        resume = 1'b0;
        step();
        checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 16'h1234}) begin
            failures++;
            $display("FAIL jump_halt_resume actual=v%b p%h required=v1 p1234", ir_valid, ir_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ir_ready = 1'b1;
        repeat (3) step();
        ir_ready = 1'b0;
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ir_valid, halted, rom_addr, ir_pc} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL async_reset actual=v%b h%b a%h p%h required=v0 h0 a0000 p0000",
                     ir_valid, halted, rom_addr, ir_pc);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, 16'(i), prog[i]}) begin
                failures++;
                $display("FAIL async_restart_%0d actual=v%b p%h required=v1 p%h", i, ir_valid, ir_pc, 16'(i));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            ir_ready  = ($urandom_range(0, 3) != 0);
            jump_en   = ($urandom_range(0, 9) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                    : 16'($urandom_range(0, 15));
            halt_req  = ($urandom_range(0, 19) == 0);
            resume    = !jump_en && ($urandom_range(0, 4) == 0);
            step();
            checks++;
            if ({ir_valid, ir_pc, ir_data, halted, rom_addr} !== {m_valid, m_irpc, m_ird, m_halt, m_pc}) begin
                failures++;
                $display("FAIL random_cycle_%0d actual=v%b p%h d%h h%b a%h required=v%b p%h d%h h%b a%h",
                         n, ir_valid, ir_pc, ir_data, halted, rom_addr,
                         m_valid, m_irpc, m_ird, m_halt, m_pc);
            end
        end
        clear_inputs();
    endtask

    initial begin
        prog[0] = 21'b111010000000000000001;
        prog[1] = 21'h0A0011;
        prog[2] = 21'h1C0102;
        prog[3] = 21'h033003;
        prog[4] = 21'h145504;
        prog[5] = 21'h0F0F05;
        prog[6] = 21'h1AB006;
        prog[7] = 21'h07C007;
        prog[8] = 21'h100008;
        prog[9] = 21'b010010000000000001001;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_jump();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1);
    end

endmodule
